// File: rtl/hil_drive_sched.sv
// Time-stamped drive scheduler for hardware-in-the-loop pins: commands queue in a FIFO
// and are applied to per-signal out/oe/x registers once the running time counter reaches them.
module hil_drive_sched #(
    parameter int NUM_SIG = 6,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step_en,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_id,
    input  logic [1:0]               cmd_val,
    input  logic [TS_W-1:0]          cmd_time,
    output logic [NUM_SIG-1:0]       sig_out,
    output logic [NUM_SIG-1:0]       sig_oe,
    output logic [NUM_SIG-1:0]       sig_x,
    output logic [TS_W-1:0]          now,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     apply_pulse,
    output logic                     err_id,
    output logic                     err_late
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 8 + 2 + TS_W;
    localparam logic [AW:0]      FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [7:0]       MAX_ID   = 8'(NUM_SIG);
    localparam logic [TS_W-1:0]  HALF     = {1'b1, {(TS_W - 1){1'b0}}};

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic [TS_W-1:0]   r_now;
    logic              r_apply;
    logic              r_err_id;
    logic              r_err_late;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_due;
    logic              w_id_ok;
    logic [7:0]        w_head_id;
    logic [1:0]        w_head_val;
    logic [TS_W-1:0]   w_head_time;
    logic [TS_W-1:0]   w_diff;

    assign w_full    = (r_level == FULL_LVL);
    assign w_empty   = (r_level == '0);
    assign cmd_ready = !w_full && !rst;
    assign w_push    = cmd_valid && cmd_ready;

    assign {w_head_id, w_head_val, w_head_time} = r_mem[r_rd_ptr];

    // Modular age of the head: anything less than half the time range behind "now" is due.
    assign w_diff  = r_now - w_head_time;
    assign w_due   = (w_diff < HALF);
    assign w_pop   = !w_empty && w_due && !rst;
    assign w_id_ok = (w_head_id != 8'd0) && (w_head_id <= MAX_ID);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_id, cmd_val, cmd_time};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_now      <= '0;
            r_apply    <= 1'b0;
            r_err_id   <= 1'b0;
            r_err_late <= 1'b0;
        end else begin
            if (step_en) begin
                r_now <= r_now + 1'b1;
            end
            r_apply    <= w_pop && w_id_ok;
            r_err_id   <= w_pop && !w_id_ok;
            r_err_late <= w_pop && w_id_ok && (w_head_time != r_now);
        end
    end

    // One small register set per driven signal; id gi+1 owns bit gi.
    for (genvar gi = 0; gi < NUM_SIG; gi++) begin : g_sig
        localparam logic [7:0] SIG_ID = 8'(gi + 1);
        logic r_out;
        logic r_oe;
        logic r_x;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_out <= 1'b0;
                r_oe  <= 1'b1;
                r_x   <= 1'b0;
            end else if (w_pop && (w_head_id == SIG_ID)) begin
                r_out <= (w_head_val == 2'd1);
                r_oe  <= (w_head_val != 2'd3);
                r_x   <= (w_head_val == 2'd2);
            end
        end

        assign sig_out[gi] = r_out;
        assign sig_oe[gi]  = r_oe;
        assign sig_x[gi]   = r_x;
    end

    assign now         = r_now;
    assign level       = r_level;
    assign apply_pulse = r_apply;
    assign err_id      = r_err_id;
    assign err_late    = r_err_late;

endmodule
